// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//
// Small first-word-fall-through instruction queue sitting between the
// instruction memory read port and the decode stage. It absorbs the one-cycle
// imem read latency so that a decode stall never loses a word already in
// flight. A taken branch from execute discards everything queued.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-low reset
//   v_i         inst_i/origaddr_i carry a valid imem read result
//   inst_i      instruction word from imem
//   origaddr_i  address of inst_i
//   stall_o     to fetch: do not issue a new address this cycle
//   flush_i     branch taken in execute: discard everything
//   v_o         to decode: inst_o/origaddr_o are valid
//   inst_o      head instruction
//   origaddr_o  head address
//   stall_i     from decode: head not consumed this cycle
//   count_o     current occupancy, 0..DEPTH
//   overflow_o  sticky error: a valid input arrived while full and was dropped
// -----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int W_WORD = 32,
  parameter int W_ADDR = 16,
  parameter int DEPTH  = 4,
  parameter int W_CNT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [W_WORD-1:0] inst_i,
  input  logic [W_ADDR-1:0] origaddr_i,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              v_o,
  output logic [W_WORD-1:0] inst_o,
  output logic [W_ADDR-1:0] origaddr_o,
  input  logic              stall_i,
  output logic [W_CNT-1:0]  count_o,
  output logic              overflow_o
);

  localparam int W_PTR = $clog2(DEPTH);

  localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(DEPTH);
  localparam logic [W_CNT-1:0] CNT_HIGH = W_CNT'(DEPTH - 1);
  localparam logic [W_CNT-1:0] CNT_ONE  = W_CNT'(1);
  localparam logic [W_PTR-1:0] PTR_ONE  = W_PTR'(1);

  logic [W_WORD-1:0] inst_mem [DEPTH];
  logic [W_ADDR-1:0] addr_mem [DEPTH];

  logic [W_PTR-1:0] head;
  logic [W_PTR-1:0] tail;
  logic [W_CNT-1:0] count;
  logic             overflow;

  logic             pop;
  logic             push;
  logic             drop;
  logic [W_CNT-1:0] count_next;

  // Outputs come straight from registers, except that a flush masks v_o in
  // the same cycle so decode never consumes a word from the wrong path.
  // stall_o asserts one entry early: the address issued last cycle still has
  // its read result in flight and needs a guaranteed slot.
  always_comb begin
    v_o        = (count != '0) && !flush_i;
    inst_o     = inst_mem[head];
    origaddr_o = addr_mem[head];
    stall_o    = (count >= CNT_HIGH);
    count_o    = count;
    overflow_o = overflow;
  end

  // A push is allowed when full only if the head leaves in the same cycle.
  // A valid word that cannot be accepted is dropped and flagged; flush
  // swallows any incoming word without flagging it.
  always_comb begin
    pop  = v_o && !stall_i;
    push = v_i && !flush_i && ((count != CNT_FULL) || pop);
    drop = v_i && !flush_i && (count == CNT_FULL) && !pop;

    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Pointers are log2(DEPTH) bits wide, so they wrap from DEPTH-1 to 0 on
  // their own. A flush rewinds both pointers rather than only emptying the
  // count, which keeps the next write landing at entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      count <= count_next;
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // Storage is cleared by reset so inst_o/origaddr_o read as zero after
  // reset, but a flush leaves the stale words in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (push) begin
      inst_mem[tail] <= inst_i;
      addr_mem[tail] <= origaddr_i;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//
// Self-checking bench for fetch_buffer. A queue-based reference model holds
// the expected contents; each scenario task drives inputs, compares at the
// falling edge and then advances the model and the clock together.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;

  localparam int W_WORD = 32;
  localparam int W_ADDR = 16;
  localparam int DEPTH  = 4;
  localparam int W_CNT  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              v_i = 1'b0;
  logic [W_WORD-1:0] inst_i = '0;
  logic [W_ADDR-1:0] origaddr_i = '0;
  logic              stall_o;
  logic              flush_i = 1'b0;
  logic              v_o;
  logic [W_WORD-1:0] inst_o;
  logic [W_ADDR-1:0] origaddr_o;
  logic              stall_i = 1'b0;
  logic [W_CNT-1:0]  count_o;
  logic              overflow_o;

  fetch_buffer #(
    .W_WORD(W_WORD),
    .W_ADDR(W_ADDR),
    .DEPTH (DEPTH),
    .W_CNT (W_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .v_i       (v_i),
    .inst_i    (inst_i),
    .origaddr_i(origaddr_i),
    .stall_o   (stall_o),
    .flush_i   (flush_i),
    .v_o       (v_o),
    .inst_o    (inst_o),
    .origaddr_o(origaddr_o),
    .stall_i   (stall_i),
    .count_o   (count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as {inst, addr} plus the sticky drop flag.
  logic [W_WORD+W_ADDR-1:0] mq[$];
  bit                       m_ovf = 1'b0;

  // Expected {v_o, stall_o, overflow_o, count_o} for the current inputs.
  function automatic logic [W_CNT+2:0] exp_status();
    logic ev;
    logic es;
    ev = (mq.size() != 0) && !flush_i;
    es = (mq.size() >= DEPTH - 1);
    return {ev, es, m_ovf, W_CNT'(mq.size())};
  endfunction

  function automatic logic exp_valid();
    return (mq.size() != 0) && !flush_i;
  endfunction

  // Apply inputs just after a rising edge, then wait for the falling edge.
  task automatic cycle_begin(input logic v, input logic [W_WORD-1:0] inst,
                             input logic [W_ADDR-1:0] addr, input logic stall,
                             input logic flush);
    v_i        = v;
    inst_i     = inst;
    origaddr_i = addr;
    stall_i    = stall;
    flush_i    = flush;
    @(negedge clk);
  endtask

  // Advance the model by one cycle from the held inputs, then clock the DUT.
  task automatic cycle_end();
    bit pop;
    if (flush_i) begin
      mq.delete();
    end else begin
      pop = (mq.size() != 0) && !stall_i;
      if (pop) void'(mq.pop_front());
      if (v_i) begin
        if (mq.size() < DEPTH) mq.push_back({inst_i, origaddr_i});
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cycle_begin(1'b0, '0, '0, 1'b0, 1'b0);
      total++;
      if ({v_o, stall_o, overflow_o, count_o, inst_o, origaddr_o} !== '0) begin
        bad++;
        $display("[TB] FAIL reset_hold: got v=%b st=%b ov=%b cnt=%0d inst=%h addr=%h want all zero",
                 v_o, stall_o, overflow_o, count_o, inst_o, origaddr_o);
      end
      cycle_end();
    end
    rst = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    cycle_begin(1'b0, '0, '0, 1'b0, 1'b0);
    total++;
    if ({v_o, stall_o, overflow_o, count_o, inst_o, origaddr_o} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_release: got v=%b st=%b ov=%b cnt=%0d inst=%h addr=%h want all zero",
               v_o, stall_o, overflow_o, count_o, inst_o, origaddr_o);
    end
    cycle_end();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) cycle_begin(1'b1, 32'h1000_0001 + i, W_ADDR'(i), 1'b0, 1'b0);
      else       cycle_begin(1'b0, '0, '0, 1'b0, 1'b0);
      total++;
      if ({v_o, stall_o, overflow_o, count_o} !== exp_status()) begin
        bad++;
        $display("[TB] FAIL stream_status c%0d: got %b want %b", i,
                 {v_o, stall_o, overflow_o, count_o}, exp_status());
      end
      if (exp_valid()) begin
        total++;
        if ({inst_o, origaddr_o} !== mq[0]) begin
          bad++;
          $display("[TB] FAIL stream_head c%0d: got %h want %h", i, {inst_o, origaddr_o}, mq[0]);
        end
      end
      total++;
      if (count_o > 1) begin
        bad++;
        $display("[TB] FAIL stream_count_max c%0d: got %0d want <=1", i, count_o);
      end
      cycle_end();
    end
  endtask

  task automatic test_stall_fill();
    // Three words while stall_o is low, then the in-flight fourth.
    for (int i = 0; i < 10; i++) begin
      if (i < 4)      cycle_begin(1'b1, 32'h3000_0000 + i, 16'h0100 + 16'(i), 1'b1, 1'b0);
      else if (i < 5) cycle_begin(1'b0, '0, '0, 1'b1, 1'b0);
      else            cycle_begin(1'b0, '0, '0, 1'b0, 1'b0);
      total++;
      if ({v_o, stall_o, overflow_o, count_o} !== exp_status()) begin
        bad++;
        $display("[TB] FAIL fill_status c%0d: got %b want %b", i,
                 {v_o, stall_o, overflow_o, count_o}, exp_status());
      end
      if (exp_valid()) begin
        total++;
        if ({inst_o, origaddr_o} !== mq[0]) begin
          bad++;
          $display("[TB] FAIL fill_head c%0d: got %h want %h", i, {inst_o, origaddr_o}, mq[0]);
        end
      end
      if (i == 4) begin
        total++;
        if ({count_o, stall_o, overflow_o} !== {W_CNT'(4), 1'b1, 1'b0}) begin
          bad++;
          $display("[TB] FAIL fill_full: got cnt=%0d st=%b ov=%b want cnt=4 st=1 ov=0",
                   count_o, stall_o, overflow_o);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      cycle_begin(1'b1, 32'h3100_0000 + i, 16'h0200 + 16'(i), 1'b1, 1'b0);
      cycle_end();
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 0) cycle_begin(1'b1, 32'hDEAD_BEEF, 16'h0BEE, 1'b0, 1'b0);
      else        cycle_begin(1'b0, '0, '0, 1'b0, 1'b0);
      total++;
      if ({v_o, stall_o, overflow_o, count_o} !== exp_status()) begin
        bad++;
        $display("[TB] FAIL fullpp_status c%0d: got %b want %b", i,
                 {v_o, stall_o, overflow_o, count_o}, exp_status());
      end
      if (exp_valid()) begin
        total++;
        if ({inst_o, origaddr_o} !== mq[0]) begin
          bad++;
          $display("[TB] FAIL fullpp_head c%0d: got %h want %h", i, {inst_o, origaddr_o}, mq[0]);
        end
      end
      if (i == 1) begin
        total++;
        if (count_o !== W_CNT'(4)) begin
          bad++;
          $display("[TB] FAIL fullpp_count_hold: got %0d want 4", count_o);
        end
      end
      if (i == 4) begin
        total++;
        if ({v_o, inst_o, origaddr_o} !== {1'b1, 32'hDEAD_BEEF, 16'h0BEE}) begin
          bad++;
          $display("[TB] FAIL fullpp_deadbeef: got v=%b %h@%h want 1 deadbeef@0bee",
                   v_o, inst_o, origaddr_o);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      cycle_begin(1'b1, 32'h5000_0000 + i, 16'h0300 + 16'(i), 1'b1, 1'b0);
      cycle_end();
    end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       cycle_begin(1'b1, 32'h5555_5555, 16'h0077, 1'b0, 1'b1);
        1:       cycle_begin(1'b1, 32'h2000_0000, 16'h0040, 1'b0, 1'b0);
        default: cycle_begin(1'b0, '0, '0, 1'b0, 1'b0);
      endcase
      total++;
      if ({v_o, stall_o, overflow_o, count_o} !== exp_status()) begin
        bad++;
        $display("[TB] FAIL flush_status c%0d: got %b want %b", i,
                 {v_o, stall_o, overflow_o, count_o}, exp_status());
      end
      if (i == 0) begin
        total++;
        if (v_o !== 1'b0) begin
          bad++;
          $display("[TB] FAIL flush_vmask: got v_o=%b want 0", v_o);
        end
      end
      if (i == 1) begin
        total++;
        if ({count_o, v_o, stall_o} !== {W_CNT'(0), 1'b0, 1'b0}) begin
          bad++;
          $display("[TB] FAIL flush_after: got cnt=%0d v=%b st=%b want 0 0 0", count_o, v_o, stall_o);
        end
      end
      if (i == 2) begin
        total++;
        if ({v_o, inst_o, origaddr_o} !== {1'b1, 32'h2000_0000, 16'h0040}) begin
          bad++;
          $display("[TB] FAIL flush_next_word: got v=%b %h@%h want 1 20000000@0040",
                   v_o, inst_o, origaddr_o);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      cycle_begin(1'b1, 32'h4000_0000 + i, 16'h0400 + 16'(i), 1'b1, 1'b0);
      cycle_end();
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 0)     cycle_begin(1'b1, 32'hBAD0_0000, 16'h0BAD, 1'b1, 1'b0);
      else if (i < 3) cycle_begin(1'b0, '0, '0, 1'b1, 1'b0);
      else            cycle_begin(1'b0, '0, '0, 1'b0, 1'b0);
      total++;
      if ({v_o, stall_o, overflow_o, count_o} !== exp_status()) begin
        bad++;
        $display("[TB] FAIL ovf_status c%0d: got %b want %b", i,
                 {v_o, stall_o, overflow_o, count_o}, exp_status());
      end
      if (exp_valid()) begin
        total++;
        if ({inst_o, origaddr_o} !== mq[0]) begin
          bad++;
          $display("[TB] FAIL ovf_head c%0d: got %h want %h", i, {inst_o, origaddr_o}, mq[0]);
        end
      end
      if (i == 8) begin
        total++;
        if (overflow_o !== 1'b1) begin
          bad++;
          $display("[TB] FAIL ovf_sticky: got %b want 1", overflow_o);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_wrap();
    int sent;
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      logic st;
      logic v;
      st = ((c / 2) % 2) == 1;
      v  = (sent < 10) && (mq.size() < DEPTH - 1);
      cycle_begin(v, 32'h6000_0000 + sent, 16'h0600 + 16'(sent), st, 1'b0);
      if (v) sent++;
      total++;
      if ({v_o, stall_o, overflow_o, count_o} !== exp_status()) begin
        bad++;
        $display("[TB] FAIL wrap_status c%0d: got %b want %b", c,
                 {v_o, stall_o, overflow_o, count_o}, exp_status());
      end
      if (exp_valid()) begin
        total++;
        if ({inst_o, origaddr_o} !== mq[0]) begin
          bad++;
          $display("[TB] FAIL wrap_head c%0d: got %h want %h", c, {inst_o, origaddr_o}, mq[0]);
        end
      end
      cycle_end();
      if (sent == 10 && mq.size() == 0) break;
    end
    total++;
    if (sent != 10 || mq.size() != 0) begin
      bad++;
      $display("[TB] FAIL wrap_complete: got sent=%0d left=%0d want 10 0", sent, mq.size());
    end
    // Refill a little, then pull reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      cycle_begin(1'b1, 32'h7000_0000 + i, 16'h0700 + 16'(i), 1'b1, 1'b0);
      cycle_end();
    end
    v_i = 1'b0;
    stall_i = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({count_o, v_o, overflow_o} !== {W_CNT'(0), 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL async_reset: got cnt=%0d v=%b ov=%b want 0 0 0", count_o, v_o, overflow_o);
    end
    mq.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic v;
      logic st;
      logic fl;
      v  = ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH - 1);
      st = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 19) == 0);
      cycle_begin(v, $urandom, W_ADDR'($urandom), st, fl);
      total++;
      if ({v_o, stall_o, overflow_o, count_o} !== exp_status()) begin
        bad++;
        $display("[TB] FAIL rand_status c%0d: got %b want %b", c,
                 {v_o, stall_o, overflow_o, count_o}, exp_status());
      end
      if (exp_valid()) begin
        total++;
        if ({inst_o, origaddr_o} !== mq[0]) begin
          bad++;
          $display("[TB] FAIL rand_head c%0d: got %h want %h", c, {inst_o, origaddr_o}, mq[0]);
        end
      end
      cycle_end();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_full_push_pop();
    test_flush();
    test_overflow();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion want completion before 200000");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small first-word-fall-through instruction queue between the instruction memory read port and the decode stage.
- Absorbs the one-cycle imem read latency so that a decode stall never loses an instruction already in flight.
- Discards all queued and in-flight instructions on a taken branch from execute.
- Throttles fetch through a registered-count stall back to the fetch stage.

Parameters:
- W_WORD, 32, instruction width.
- W_ADDR, 16, instruction address width.
- DEPTH, 4, queue entries; power of two, minimum 2.
- W_CNT, 3, occupancy counter width; must hold the value DEPTH (log2(DEPTH)+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- v_i  in  1  inst_i/origaddr_i carry a valid imem read result this cycle.
- inst_i  in  W_WORD  instruction word from imem.
- origaddr_i  in  W_ADDR  address of inst_i.
- stall_o  out  1  to fetch stage: do not issue a new address this cycle.
- flush_i  in  1  branch taken in execute: discard everything.
- v_o  out  1  to decode: inst_o/origaddr_o are valid.
- inst_o  out  W_WORD  head instruction.
- origaddr_o  out  W_ADDR  head address.
- stall_i  in  1  from decode: head not consumed this cycle.
- count_o  out  W_CNT  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky error: a valid input arrived while full and was dropped.

Behaviour:
Reset:
- While rst=0, asynchronously clear head pointer, tail pointer, count, all storage entries and overflow_o to 0.
- Consequently v_o=0, inst_o=0, origaddr_o=0, stall_o=0 and count_o=0 during reset and in the first cycle after release.

Storage:
- Circular array of DEPTH entries {inst, origaddr}.
- Head and tail pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.

Outputs (combinational from registers):
- v_o = (count != 0) && !flush_i.
- inst_o and origaddr_o = the entry at head. They remain at the stale head entry when count=0.
- stall_o = (count >= DEPTH-1). This leaves one slot for the read already in flight from the previous fetch address.
- count_o = count.

Per-cycle events (no flush):
- pop = v_o && !stall_i. Head advances by 1.
- push = v_i && (count < DEPTH || pop). Write at tail; tail advances by 1.
- count next value = count + push - pop.
- Simultaneous push and pop when full: both occur, and count stays at DEPTH.
- Simultaneous push and pop when count=1: the head entry leaves and the new entry becomes head next cycle. There is no bypass: an input reaches v_o no earlier than the cycle after it arrives, so latency is 1 cycle.
- v_i while count=DEPTH and no pop: input dropped, overflow_o set to 1 (sticky until reset). This is a fetch-protocol violation that the stall_o rule must make unreachable.

Flush:
- flush_i=1 takes priority over everything.
- Head, tail and count are cleared to 0.
- Any v_i in the same cycle is discarded; no overflow is flagged.
- No pop occurs, and v_o is forced to 0 in the flush cycle.
- Storage contents are not cleared.
- The next cycle shows count=0, v_o=0, stall_o=0.

Other rules:
- Reset mid-operation: queue contents are lost immediately. There is no requirement on in-flight v_i around the deassertion edge beyond the cleared state.
- Ordering: strict FIFO. origaddr always travels with its own inst.

Test Plan:
1. Reset then stream: rst low 2 cycles, release; v_i=1 with inst 0x1000_0001..0x1000_0006 at addresses 0x0000..0x0005, stall_i=0.
   - v_o rises one cycle after the first v_i.
   - Outputs appear in order, one per cycle, each with its matching address.
   - count_o never exceeds 1.
2. Decode stall fill: stall_i=1, v_i=1 every cycle while stall_o=0, plus one extra in-flight word after stall_o rises.
   - count_o reaches 4 with DEPTH=4.
   - stall_o=1 from count 3 onward; overflow_o stays 0.
   - Releasing stall_i drains all 4 in order.
3. Full with simultaneous push and pop: count=4, stall_i=0, v_i=1 with 0xDEAD_BEEF.
   - Head pops, new word is enqueued, count_o stays 4.
   - 0xDEAD_BEEF emerges 4 pops later.
4. Flush with input: count=3, flush_i=1 and v_i=1 in the same cycle.
   - v_o=0 in that cycle; next cycle count_o=0, v_o=0, stall_o=0.
   - The first v_i after the flush (inst 0x2000_0000, address 0x0040) is the next output.
5. Overflow: force v_i=1 with count=4, stall_i=1.
   - Word dropped, overflow_o=1 and stays 1.
   - Queue contents are unchanged.
6. Wrap-around: 10 pushes and pops with a pattern of stall_i toggling every 2 cycles.
   - Pointers wrap past entry 3.
   - Output sequence equals input sequence exactly.
   - Asynchronous reset asserted mid-stream clears count_o and v_o immediately.
